// File: rtl/dtc_pulse_gen_pkg.sv
// Shared types for the pulse generator: FSM state encoding and counter sizing.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package dtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bits needed to hold values 0..maxval; never less than one bit.
    function automatic int cnt_w(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/dtc_pulse_gen_if.sv
// Code request channel into the pulse generator (valid/ready).
// Latency: n/a (wires only).
// Backpressure: producer holds in_code while in_valid && !in_ready.
interface dtc_pulse_gen_if #(
    parameter int CODE_W = 8
);
    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_code,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_code,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/dtc_pulse_gen_code_fifo.sv
// Synchronous code buffer, DEPTH x W, head visible combinationally on pop_dat.
// Latency: pushed entry readable the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module dtc_code_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic         nxt_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  occ;
    logic [AW:0]  nxt_occ;
    logic         wr_en;
    logic         rd_en;

    // Extra MSB on each pointer separates a full buffer from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign occ      = wr_ptr - rd_ptr;
    assign nxt_occ  = occ + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    assign nxt_full = (nxt_occ == (AW+1)'(DEPTH));
    assign pop_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dtc_pulse_gen.sv
// Clocked DTC: one high pulse of exactly `code` clk periods per accepted code, GAP_MIN low between.
// Latency: out rises one edge after accept when idle; pulse_done on the falling edge.
// Backpressure: in_ready is registered !full; a full buffer refuses even if a pop shares the edge.
module dtc_pulse_gen
    import dtc_pkg::*;
#(
    parameter int CODE_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MIN    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    dtc_pulse_gen_if.slave    cif,
    output logic              out,
    output logic              busy,
    output logic              pulse_done,
    output logic [CODE_W-1:0] done_code
);
    localparam int GW = cnt_w(GAP_MIN);

    state_t            state;
    logic [CODE_W-1:0] cnt;
    logic [CODE_W-1:0] cur_code;
    logic [GW-1:0]     gcnt;
    logic              in_ready_q;

    logic              push;
    logic              pop;
    logic [CODE_W-1:0] fifo_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_nxt_full;
    logic              gap_done;

    assign cif.in_ready = in_ready_q;
    assign push         = cif.in_valid && in_ready_q && !fifo_full;
    assign gap_done     = (state == GAP) && (gcnt == GW'(1));
    // A new pulse launches from IDLE or straight out of an expiring gap.
    assign pop          = !fifo_empty && ((state == IDLE) || gap_done);
    assign busy         = (state != IDLE) || !fifo_empty;

    dtc_code_fifo #(
        .W     (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_dat (cif.in_code),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .nxt_full (fifo_nxt_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= !fifo_nxt_full;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_code   <= '0;
            gcnt       <= '0;
            out        <= 1'b0;
            pulse_done <= 1'b0;
            done_code  <= '0;
        end else begin
            pulse_done <= 1'b0;
            if (pop) begin
                cur_code <= fifo_dat;
                cnt      <= fifo_dat;
                if (fifo_dat != '0) begin
                    out   <= 1'b1;
                    state <= HIGH;
                end else begin
                    // Zero-width request: report completion without ever raising out.
                    out        <= 1'b0;
                    pulse_done <= 1'b1;
                    done_code  <= '0;
                    gcnt       <= GW'(GAP_MIN);
                    state      <= GAP;
                end
            end else begin
                case (state)
                    IDLE: begin
                        out <= 1'b0;
                    end
                    HIGH: begin
                        if (cnt == CODE_W'(1)) begin
                            out        <= 1'b0;
                            pulse_done <= 1'b1;
                            done_code  <= cur_code;
                            gcnt       <= GW'(GAP_MIN);
                            state      <= GAP;
                        end
                        cnt <= cnt - 1'b1;
                    end
                    GAP: begin
                        if (gap_done) begin
                            state <= IDLE;
                        end
                        gcnt <= gcnt - 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        out   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dtc_pulse_gen.sv
// Directed bench for dtc_pulse_gen (GAP_MIN=2): cycle-exact edge checks plus an ideal-TDC monitor.
module tb_dtc_pulse_gen;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       out;
    logic       busy;
    logic       pulse_done;
    logic [7:0] done_code;

    always #5 clk = ~clk;

    dtc_pulse_gen_if #(.CODE_W(8)) cif ();

    dtc_pulse_gen #(
        .CODE_W     (8),
        .FIFO_DEPTH (4),
        .GAP_MIN    (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cif        (cif),
        .out        (out),
        .busy       (busy),
        .pulse_done (pulse_done),
        .done_code  (done_code)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ideal TDC with t_res = one clk period: counts high samples per pulse.
    int   width_q[$];
    int   gap_q[$];
    int   done_q[$];
    int   hi_len   = 0;
    int   lo_len   = 0;
    int   bad_edge = 0;
    logic prev_out = 1'b0;
    logic seen     = 1'b0;
    logic mon_clr;

    always @(negedge clk) begin
        if (!rstn || mon_clr) begin
            hi_len   = 0;
            lo_len   = 0;
            prev_out = 1'b0;
            seen     = 1'b0;
            if (mon_clr) begin
                width_q.delete();
                gap_q.delete();
                done_q.delete();
                bad_edge = 0;
            end
        end else begin
            if (pulse_done) done_q.push_back(int'(done_code));
            if (prev_out && !out && !pulse_done) bad_edge++;
            if (pulse_done && !(prev_out && !out) && done_code != 8'd0) bad_edge++;
            if (out) begin
                if (!prev_out && seen) gap_q.push_back(lo_len);
                hi_len++;
            end else begin
                if (prev_out) begin
                    width_q.push_back(hi_len);
                    seen   = 1'b1;
                    hi_len = 0;
                    lo_len = 0;
                end
                if (seen) lo_len++;
            end
            prev_out = out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, output int waited);
        cif.in_code  = c;
        cif.in_valid = 1'b1;
        waited = 0;
        while (!cif.in_ready && waited < 600) begin
            tick();
            waited++;
        end
        chk("ready_wait_bound", 32'(waited < 600), 1);
        tick();
        cif.in_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        int b;
        b = 0;
        while (done_q.size() < n && b < 3000) begin
            tick();
            b++;
        end
        chk("done_count", done_q.size(), n);
        repeat (4) tick();
    endtask

    task automatic clr();
        tick();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    int w;
    int exp_d[6];

    initial begin
        cif.in_valid = 1'b0;
        cif.in_code  = 8'd0;
        mon_clr      = 1'b0;

        // Reset state
        #1 rstn = 1'b0;
        #2;
        chk("rst_out", out, 0);
        chk("rst_pulse_done", pulse_done, 0);
        chk("rst_done_code", done_code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", cif.in_ready, 0);
        @(posedge clk);
        tick();
        rstn = 1'b1;
        chk("rel_in_ready_before_edge", cif.in_ready, 0);
        tick();
        chk("rel_in_ready", cif.in_ready, 1);

        // Single code 5: rise one edge after accept, high exactly 5 cycles
        clr();
        send(8'd5, w);
        chk("c5_low_at_accept", out, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("c5_high", out, 1);
            chk("c5_no_done_early", pulse_done, 0);
        end
        tick();
        chk("c5_fall", out, 0);
        chk("c5_done", pulse_done, 1);
        chk("c5_done_code", done_code, 5);
        tick();
        chk("c5_done_one_cycle", pulse_done, 0);
        chk("c5_busy_in_gap", busy, 1);
        tick();
        chk("c5_idle_busy", busy, 0);

        // Back-to-back 3 then 2 with GAP_MIN=2
        clr();
        send(8'd3, w);
        send(8'd2, w);
        wait_dones(2);
        chk("b2b_npulses", width_q.size(), 2);
        chk("b2b_w0", width_q[0], 3);
        chk("b2b_w1", width_q[1], 2);
        chk("b2b_ngaps", gap_q.size(), 1);
        chk("b2b_gap", gap_q[0], 2);
        chk("b2b_d0", done_q[0], 3);
        chk("b2b_d1", done_q[1], 2);

        // Code 0 then code 1
        clr();
        send(8'd0, w);
        chk("z_no_done_at_accept", pulse_done, 0);
        send(8'd1, w);
        chk("z_done", pulse_done, 1);
        chk("z_done_code", done_code, 0);
        chk("z_out_low", out, 0);
        tick();
        chk("z_gap_low", out, 0);
        chk("z_done_cleared", pulse_done, 0);
        tick();
        chk("z_c1_high", out, 1);
        tick();
        chk("z_c1_fall", out, 0);
        chk("z_c1_done", pulse_done, 1);
        chk("z_c1_done_code", done_code, 1);
        repeat (3) tick();
        chk("z_npulses", width_q.size(), 1);

        // Fill: 255 then 1..5 held valid, depth 4
        clr();
        send(8'd255, w);
        for (int c = 1; c <= 4; c++) send(8'(c), w);
        chk("full_ready_low", cif.in_ready, 0);
        chk("full_busy", busy, 1);
        send(8'd5, w);
        chk("full_ready_wait", w, 254);
        wait_dones(6);
        exp_d = '{255, 1, 2, 3, 4, 5};
        chk("full_npulses", width_q.size(), 6);
        chk("full_ngaps", gap_q.size(), 5);
        for (int i = 0; i < 6; i++) begin
            chk("full_width", width_q[i], exp_d[i]);
            chk("full_done_code", done_q[i], exp_d[i]);
        end
        for (int i = 0; i < 5; i++) chk("full_gap", gap_q[i], 2);
        chk("full_edges", bad_edge, 0);

        // Async reset at cycle 3 of code 10, with code 7 queued
        clr();
        send(8'd10, w);
        send(8'd7, w);
        tick();
        tick();
        chk("ar_high_before", out, 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_out", out, 0);
        chk("ar_pulse_done", pulse_done, 0);
        chk("ar_busy", busy, 0);
        chk("ar_in_ready", cif.in_ready, 0);
        chk("ar_done_code", done_code, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("ar_no_done", done_q.size(), 0);
        chk("ar_flushed_busy", busy, 0);
        chk("ar_in_ready_back", cif.in_ready, 1);
        repeat (3) tick();
        chk("ar_flushed_out", out, 0);
        clr();
        send(8'd4, w);
        wait_dones(1);
        chk("ar_new_npulses", width_q.size(), 1);
        chk("ar_new_width", width_q[0], 4);
        chk("ar_new_done", done_q[0], 4);

        // Loopback into ideal TDC
        clr();
        send(8'd1, w);
        send(8'd7, w);
        send(8'd200, w);
        wait_dones(3);
        chk("tdc_n", width_q.size(), 3);
        chk("tdc_1", width_q[0], 1);
        chk("tdc_7", width_q[1], 7);
        chk("tdc_200", width_q[2], 200);
        chk("tdc_edges", bad_edge, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
